// File: rtl/ext_in_port_pkg.sv
// Shared constants and FSM encoding for the IN-instruction input port.
package ext_in_port_pkg;

  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [7:0] IN_RESET = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/ext_in_port_if.sv
// Valid/ready byte handshake between an external producer and the input port.
interface ext_in_port_if;

  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;

  modport master (output ext_data, output ext_valid, input ext_ready);
  modport slave  (input ext_data, input ext_valid, output ext_ready);

endinterface

// File: rtl/in_fifo.sv
// Synchronous byte FIFO with a dedicated occupancy counter; no read bypass.
module in_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write on accepted push.
  // NOTE: data storage carries no reset; r_level decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ext_in_port.sv
// IN-instruction input port: buffers producer bytes and hands one to write-back per IN,
// stalling the PC on an empty buffer for at most TIMEOUT+1 cycles.
module ext_in_port
  import ext_in_port_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  ext_in_port_if.slave           i_ext,
  input  logic [3:0]             i_op,
  output logic [7:0]             o_in_data,
  output logic                   o_stall,
  output logic                   o_err,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic          r_ready_en;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_is_in;
  logic          w_load_timer;
  logic          w_dec_timer;
  logic          w_take_head;
  logic          w_take_zero;

  assign w_is_in         = (i_op == OP_IN);
  assign i_ext.ext_ready = r_ready_en && !w_full;
  assign w_push          = i_ext.ext_valid && i_ext.ext_ready;

  in_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (i_ext.ext_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (o_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Hold ext_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ready_en <= 1'b0;
    else     r_ready_en <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, stall decode and completion strobes.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    w_pop        = 1'b0;
    w_load_timer = 1'b0;
    w_dec_timer  = 1'b0;
    w_take_head  = 1'b0;
    w_take_zero  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_in) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_take_head = 1'b1;
          end else begin
            o_stall      = 1'b1;
            w_load_timer = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_is_in) begin
          // Opcode changed under a stall: abandon the IN without side effects.
          w_state_next = ST_IDLE;
        end else if (!w_empty) begin
          w_pop        = 1'b1;
          w_take_head  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_timer != '0) begin
          o_stall     = 1'b1;
          w_dec_timer = 1'b1;
        end else begin
          w_take_zero  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (rst) o_stall = 1'b0;
  end

  // Stall timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_timer <= '0;
    else if (w_load_timer) r_timer <= TW'(TIMEOUT);
    else if (w_dec_timer)  r_timer <= r_timer - TW'(1);
  end

  // Write-back byte and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_in_data <= IN_RESET;
      o_err     <= 1'b0;
    end else begin
      if (w_take_head)      o_in_data <= w_head;
      else if (w_take_zero) o_in_data <= 8'h00;
      if (w_take_zero)      o_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_in_port.sv
// Self-checking bench for ext_in_port: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ext_in_port;
  import ext_in_port_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic [7:0] in_data;
  logic       stall;
  logic       err;
  logic [2:0] level;

  int total      = 0;
  int bad        = 0;
  int stall_seen = 0;

  ext_in_port_if u_if ();

  ext_in_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_ext     (u_if),
    .i_op      (op),
    .o_in_data (in_data),
    .o_stall   (stall),
    .o_err     (err),
    .o_level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a count of cycles the current IN has been stalled.
  logic [7:0] q[$];
  int         m_cnt  = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_err  = 1'b0;
  logic       m_en   = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_data = 8'h00;
      m_err  = 1'b0;
      m_en   = 1'b0;
    end else begin
      automatic bit         rdy  = m_en && (q.size() < DEPTH);
      automatic bit         push = u_if.ext_valid && rdy;
      automatic logic [7:0] pd   = u_if.ext_data;
      if (op == OP_IN) begin
        if (q.size() != 0) begin
          m_data = q.pop_front();
          m_cnt  = 0;
        end else if (m_cnt == TIMEOUT + 1) begin
          m_data = 8'h00;
          m_err  = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      if (push) q.push_back(pd);
      m_en = 1'b1;
    end
  end

  function automatic logic exp_stall();
    return !rst && (op == OP_IN) && (q.size() == 0) && (m_cnt <= TIMEOUT);
  endfunction

  function automatic logic exp_ready();
    return !rst && m_en && (q.size() < DEPTH);
  endfunction

  // Per-cycle comparison, mid-cycle away from the active edge.
  always @(negedge clk) begin
    check("stall", stall, exp_stall());
    check("ext_ready", u_if.ext_ready, exp_ready());
    check("level", level, q.size());
    check("in_data", in_data, m_data);
    check("err", err, m_err);
    if (stall === 1'b1) stall_seen++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic logic [7:0] fill_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    automatic logic [7:0] drain_a[4] = '{8'hA3, 8'hA4, 8'hA5, 8'hA6};

    // Reset with producer valid and an IN opcode present.
    rst = 1'b1;
    op  = OP_IN;
    u_if.ext_valid = 1'b1;
    u_if.ext_data  = 8'hEE;
    step(3);
    check("rst_ready", u_if.ext_ready, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_in_data", in_data, 8'h00);
    check("rst_level", level, 3'd0);
    rst = 1'b0;
    op  = 4'h0;
    u_if.ext_valid = 1'b0;
    step(1);
    check("ready_after_rst", u_if.ext_ready, 1'b1);

    // Fill to DEPTH.
    for (int i = 0; i < 4; i++) begin
      u_if.ext_valid = 1'b1;
      u_if.ext_data  = fill_a[i];
      step(1);
    end
    u_if.ext_valid = 1'b0;
    check("full_level", level, 3'd4);
    check("full_ready", u_if.ext_ready, 1'b0);
    check("model_full", q.size(), 4);

    // Four back-to-back INs, no stall.
    stall_seen = 0;
    op = OP_IN;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("b2b_data", in_data, fill_a[i]);
    end
    op = 4'h0;
    check("b2b_nostall", stall_seen, 0);
    check("model_b2b", m_data, 8'h44);

    // IN on empty FIFO, byte arrives three cycles later.
    stall_seen = 0;
    op = OP_IN;
    step(3);
    u_if.ext_valid = 1'b1;
    u_if.ext_data  = 8'h5A;
    step(1);
    u_if.ext_valid = 1'b0;
    step(1);
    op = 4'h0;
    check("late_data", in_data, 8'h5A);
    check("late_stall_cycles", stall_seen, 4);
    check("late_err", err, 1'b0);

    // IN on empty FIFO with no producer: timeout.
    stall_seen = 0;
    op = OP_IN;
    step(6);
    op = 4'h0;
    check("to_stall_cycles", stall_seen, 5);
    check("to_data", in_data, 8'h00);
    check("to_err", err, 1'b1);
    check("model_to_err", m_err, 1'b1);

    // err is sticky across a later successful IN.
    u_if.ext_valid = 1'b1;
    u_if.ext_data  = 8'h66;
    step(1);
    u_if.ext_valid = 1'b0;
    op = OP_IN;
    step(1);
    op = 4'h0;
    check("sticky_data", in_data, 8'h66);
    check("sticky_err", err, 1'b1);

    // Simultaneous push/pop below full, pop-only at full, order preserved.
    u_if.ext_valid = 1'b1;
    u_if.ext_data = 8'hA1; step(1);
    u_if.ext_data = 8'hA2; step(1);
    u_if.ext_data = 8'hA3; step(1);
    u_if.ext_data = 8'hA4;
    op = OP_IN;
    step(1);
    check("pp_data", in_data, 8'hA1);
    check("pp_level", level, 3'd3);
    op = 4'h0;
    u_if.ext_data = 8'hA5;
    step(1);
    check("pp_full_level", level, 3'd4);
    u_if.ext_data = 8'hA6;
    op = OP_IN;
    step(1);
    check("full_pop_data", in_data, 8'hA2);
    check("full_pop_level", level, 3'd3);
    op = 4'h0;
    step(1);
    check("refill_level", level, 3'd4);
    u_if.ext_valid = 1'b0;
    op = OP_IN;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("drain_data", in_data, drain_a[i]);
    end
    op = 4'h0;

    // Reset asserted mid-WAIT.
    op = OP_IN;
    step(2);
    check("wait_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_wait_stall", stall, 1'b0);
    check("rst_wait_ready", u_if.ext_ready, 1'b0);
    step(2);
    rst = 1'b0;
    op  = 4'h0;
    step(1);
    check("post_rst_level", level, 3'd0);
    check("post_rst_err", err, 1'b0);
    check("post_rst_ready", u_if.ext_ready, 1'b1);
    u_if.ext_valid = 1'b1;
    u_if.ext_data  = 8'h77;
    step(1);
    u_if.ext_valid = 1'b0;
    stall_seen = 0;
    op = OP_IN;
    step(1);
    op = 4'h0;
    check("post_rst_in", in_data, 8'h77);
    check("post_rst_nostall", stall_seen, 0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
